maq_ms: RTL and testbench

- Minutes/seconds timekeeping stage of the digital clock. Sits directly upstream of the hours counter.
- Divides the system clock down to a 1 Hz tick and counts seconds and minutes in BCD, 00:00 to 59:59.
- Emits a one-cycle carry pulse on the 59:59 -> 00:00 rollover. This pulse drives the hours block's add input; the hours enable is tied high.
- Provides a button-driven set mode for adjusting minutes and seconds.

---
 rtl/maq_ms.sv | 203 ++++++++++++++++++++
 tb/tb_maq_ms.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maq_ms.sv
// maq_ms: minutes/seconds BCD timekeeper with a 1 Hz prescaler, button-driven set mode and hour carry.
// Optional button debounce is built in when MAQMS_DEBOUNCE_EN is defined.
module maq_ms #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       maqms_clock,
  input  logic       maqms_reset,
  input  logic       maqms_mode,
  input  logic       maqms_inc,
  output logic [3:0] maqms_sec_uni,
  output logic [2:0] maqms_sec_dez,
  output logic [3:0] maqms_min_uni,
  output logic [2:0] maqms_min_dez,
  output logic       maqms_carry,
  output logic [1:0] maqms_state
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_MIN = 2'd1,
    ST_SET_SEC = 2'd2
  } state_t;

  if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_param_check
    $error("maq_ms: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
  end

  function automatic logic uni_wrap(input logic [3:0] u);
    return u >= 4'd9;
  endfunction

  function automatic logic [3:0] uni_next(input logic [3:0] u);
    return (u >= 4'd9) ? 4'd0 : u + 4'd1;
  endfunction

  function automatic logic dez_wrap(input logic [2:0] d);
    return d >= 3'd5;
  endfunction

  function automatic logic [2:0] dez_next(input logic [2:0] d);
    return (d >= 3'd5) ? 3'd0 : d + 3'd1;
  endfunction

  // Button conditioning: bit 0 is mode, bit 1 is inc
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] lvl;
  logic [1:0] prev;
  logic [1:0] press;
  logic       mode_p;
  logic       inc_p;

  always_ff @(posedge maqms_clock or negedge maqms_reset) begin
    if (!maqms_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {maqms_inc, maqms_mode};
      sync2 <= sync1;
    end
  end

`ifdef MAQMS_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    deb_lvl;

  // A new synchronized level must persist DEB_CYCLES samples before it is accepted
  always_ff @(posedge maqms_clock or negedge maqms_reset) begin
    if (!maqms_reset) begin
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      deb_lvl    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = deb_lvl;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge maqms_clock or negedge maqms_reset) begin
    if (!maqms_reset) begin
      prev <= '0;
    end else begin
      prev <= lvl;
    end
  end

  assign press  = lvl & ~prev;
  assign mode_p = press[0];
  assign inc_p  = press[1];

  // Mode FSM
  state_t state_q;
  state_t state_d;
  logic   run_en;
  logic   min_set_en;
  logic   sec_set_en;

  always_ff @(posedge maqms_clock or negedge maqms_reset) begin
    if (!maqms_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      case (state_q)
        ST_RUN:     state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_SET_SEC;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    run_en     = 1'b0;
    min_set_en = 1'b0;
    sec_set_en = 1'b0;
    case (state_q)
      ST_RUN:     run_en     = 1'b1;
      ST_SET_MIN: min_set_en = 1'b1;
      ST_SET_SEC: sec_set_en = 1'b1;
      default:    ;
    endcase
  end

  assign maqms_state = state_q;

  // Timekeeping datapath
  logic [PW-1:0] presc;
  logic          tick;
  logic          sec_roll;
  logic          min_roll;
  logic          inc_min;
  logic          inc_sec;
  logic          sec_step;
  logic          min_step;

  assign tick     = run_en && (presc == PW'(TICK_DIV - 1));
  assign sec_roll = uni_wrap(maqms_sec_uni) && dez_wrap(maqms_sec_dez);
  assign min_roll = uni_wrap(maqms_min_uni) && dez_wrap(maqms_min_dez);
  // A mode press in the same cycle swallows the increment
  assign inc_min  = min_set_en && inc_p && !mode_p;
  assign inc_sec  = sec_set_en && inc_p && !mode_p;
  assign sec_step = tick || inc_sec;
  assign min_step = (tick && sec_roll) || inc_min;

  // Prescaler frozen at 0 outside RUN and restarted on any mode change
  always_ff @(posedge maqms_clock or negedge maqms_reset) begin
    if (!maqms_reset) begin
      presc <= '0;
    end else if (!run_en || mode_p || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge maqms_clock or negedge maqms_reset) begin
    if (!maqms_reset) begin
      maqms_sec_uni <= '0;
      maqms_sec_dez <= '0;
      maqms_min_uni <= '0;
      maqms_min_dez <= '0;
      maqms_carry   <= 1'b0;
    end else begin
      if (sec_step) begin
        maqms_sec_uni <= uni_next(maqms_sec_uni);
        if (uni_wrap(maqms_sec_uni)) begin
          maqms_sec_dez <= dez_next(maqms_sec_dez);
        end
      end
      if (min_step) begin
        maqms_min_uni <= uni_next(maqms_min_uni);
        if (uni_wrap(maqms_min_uni)) begin
          maqms_min_dez <= dez_next(maqms_min_dez);
        end
      end
      maqms_carry <= tick && sec_roll && min_roll;
    end
  end

endmodule

// File: tb/tb_maq_ms.sv
// tb_maq_ms: directed bench for maq_ms with a cycle-level behavioural model of time, mode and button presses.
module tb_maq_ms;

  localparam int TD  = 4;
  localparam int DEB = 8;
`ifdef MAQMS_DEBOUNCE_EN
  localparam int LAT  = DEB + 3;
  localparam int HOLD = DEB + 2;
  localparam int GAP  = DEB + 2;
  localparam int HELD = 2 * DEB + 4;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 1;
  localparam int GAP  = 1;
  localparam int HELD = 6;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic       inc   = 1'b0;
  logic [3:0] sec_uni;
  logic [2:0] sec_dez;
  logic [3:0] min_uni;
  logic [2:0] min_dez;
  logic       carry;
  logic [1:0] state;

  maq_ms #(.TICK_DIV(TD), .DEB_CYCLES(DEB)) dut (
    .maqms_clock  (clk),
    .maqms_reset  (rst_n),
    .maqms_mode   (mode),
    .maqms_inc    (inc),
    .maqms_sec_uni(sec_uni),
    .maqms_sec_dez(sec_dez),
    .maqms_min_uni(min_uni),
    .maqms_min_dez(min_dez),
    .maqms_carry  (carry),
    .maqms_state  (state)
  );

  always #5 clk = ~clk;

  // Model: time as total seconds, input history as shift registers of raw samples
  typedef struct {
    int        total;
    int        st;
    int        presc;
    bit        carry;
    bit [15:0] hm;
    bit [15:0] hi;
    bit        dbm;
    bit        dbi;
    bit        pm;
    bit        pi;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.total = 0; z.st = 0; z.presc = 0; z.carry = 1'b0;
    z.hm = '0; z.hi = '0; z.dbm = 1'b0; z.dbi = 1'b0; z.pm = 1'b0; z.pi = 1'b0;
    return z;
  endfunction

`ifdef MAQMS_DEBOUNCE_EN
  function automatic bit settled(input bit [15:0] h, input bit db);
    for (int k = 2; k < DEB + 2; k++) if (h[k] == db) return 1'b0;
    return 1'b1;
  endfunction
`endif

  function automatic mdl_t mdl_step(input mdl_t s, input bit mi, input bit ii);
    mdl_t n;
    bit pm;
    bit pi;
    bit c;
    n = s;
    n.hm = {s.hm[14:0], mi};
    n.hi = {s.hi[14:0], ii};
`ifdef MAQMS_DEBOUNCE_EN
    pm = s.pm;
    pi = s.pi;
    n.pm = 1'b0;
    n.pi = 1'b0;
    if (settled(n.hm, s.dbm)) begin n.dbm = ~s.dbm; n.pm = n.dbm; end
    if (settled(n.hi, s.dbi)) begin n.dbi = ~s.dbi; n.pi = n.dbi; end
`else
    pm = n.hm[2] & ~n.hm[3];
    pi = n.hi[2] & ~n.hi[3];
`endif
    c = 1'b0;
    if (s.st == 0) begin
      if (s.presc == TD - 1) begin
        n.presc = 0;
        if (s.total == 3599) begin n.total = 0; c = 1'b1; end
        else n.total = s.total + 1;
      end else begin
        n.presc = s.presc + 1;
      end
    end
    if (pm) begin
      n.st = (s.st + 1) % 3;
      n.presc = 0;
    end else if (pi && s.st == 1) begin
      n.total = (((n.total / 60) + 1) % 60) * 60 + n.total % 60;
    end else if (pi && s.st == 2) begin
      n.total = (n.total / 60) * 60 + ((n.total % 60) + 1) % 60;
    end
    if (n.st != 0) n.presc = 0;
    n.carry = c;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_zero();
    else        m <= mdl_step(m, mode, inc);
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_time(input string name, input int mm, input int ss);
    chk({name, "_sec_uni"}, int'(sec_uni), ss % 10);
    chk({name, "_sec_dez"}, int'(sec_dez), ss / 10);
    chk({name, "_min_uni"}, int'(min_uni), mm % 10);
    chk({name, "_min_dez"}, int'(min_dez), mm / 10);
  endtask

  task automatic cmp_model();
    chk("model_sec_uni", int'(sec_uni), (m.total % 60) % 10);
    chk("model_sec_dez", int'(sec_dez), (m.total % 60) / 10);
    chk("model_min_uni", int'(min_uni), (m.total / 60) % 10);
    chk("model_min_dez", int'(min_dez), (m.total / 60) / 10);
    chk("model_state", int'(state), m.st);
    chk("model_carry", int'(carry), int'(m.carry));
  endtask

  // Advance one cycle and compare every output against the model
  task automatic cyc();
    @(negedge clk);
    if (chk_en) cmp_model();
  endtask

  task automatic press(input bit bm, input bit bi, input int hold, input int gap);
    int last;
    last = (hold > LAT) ? hold : LAT;
    mode = bm;
    inc  = bi;
    for (int k = 1; k <= last; k++) begin
      cyc();
      if (k == hold) begin mode = 1'b0; inc = 1'b0; end
    end
    mode = 1'b0;
    inc  = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic press_n(input bit bm, input bit bi, input int count);
    repeat (count) press(bm, bi, HOLD, GAP);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ncar;
    int s0;
    int m0;

    repeat (3) @(negedge clk);
    chk_time("reset", 0, 0);
    chk("reset_state", int'(state), 0);
    chk("reset_carry", int'(carry), 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // 40 cycles of RUN at TICK_DIV=4
    ncar = 0;
    repeat (40) begin cyc(); if (carry) ncar++; end
    chk_time("run40", 0, 10);
    chk("run40_state", int'(state), 0);
    chk("run40_carry_count", ncar, 0);

    // Preload 59:58 and watch the rollover
    press(1'b1, 1'b0, HOLD, GAP);
    press_n(1'b0, 1'b1, (59 - m.total / 60 + 60) % 60);
    press(1'b1, 1'b0, HOLD, GAP);
    press_n(1'b0, 1'b1, (58 - m.total % 60 + 60) % 60);
    press(1'b1, 1'b0, HOLD, 0);
    chk_time("preload", 59, 58);
    chk("preload_state", int'(state), 0);
    ncar = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 3) chk_time("pre_roll", 59, 59);
      if (carry) begin ncar++; chk_time("carry_at", 0, 0); end
    end
    chk("carry_pulses", ncar, 1);

    // SET_MIN with 61 increments wraps past 59
    press(1'b1, 1'b0, HOLD, GAP);
    s0 = m.total % 60;
    press_n(1'b0, 1'b1, 61);
    chk("setmin_state", int'(state), 1);
    chk_time("setmin", 1, s0);
    chk("setmin_carry", int'(carry), 0);

    // Mode and inc together: mode wins
    press(1'b1, 1'b1, HOLD, GAP);
    chk("both_state", int'(state), 2);
    chk("both_min_uni", int'(min_uni), 1);
    chk("both_min_dez", int'(min_dez), 0);

    // A held inc counts once
    s0 = m.total % 60;
    press(1'b0, 1'b1, HELD, GAP);
    chk_time("held", 1, (s0 + 1) % 60);

    // Set 12:34, run two cycles, then reset asynchronously
    press(1'b1, 1'b0, HOLD, GAP);
    press(1'b1, 1'b0, HOLD, GAP);
    press_n(1'b0, 1'b1, (12 - m.total / 60 + 60) % 60);
    press(1'b1, 1'b0, HOLD, GAP);
    press_n(1'b0, 1'b1, (34 - m.total % 60 + 60) % 60);
    press(1'b1, 1'b0, HOLD, 0);
    chk_time("preset", 12, 34);
    chk("preset_state", int'(state), 0);
    cyc();
    cyc();
    chk_time("presc2", 12, 34);
    #2 rst_n = 1'b0;
    #1;
    chk_time("async_reset", 0, 0);
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_carry", int'(carry), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

`ifdef MAQMS_DEBOUNCE_EN
    // Debounce: short glitch ignored, long pulse counted once after DEB+3 edges
    press(1'b1, 1'b0, HOLD, GAP);
    press(1'b1, 1'b0, HOLD, GAP);
    chk("deb_state", int'(state), 2);
    s0 = m.total % 60;
    m0 = m.total / 60;
    inc = 1'b1;
    repeat (5) cyc();
    inc = 1'b0;
    repeat (20) cyc();
    chk_time("deb_short", m0, s0);
    inc = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 12) inc = 1'b0;
      if (k == 10) chk_time("deb_edge10", m0, s0);
      if (k == 11) chk_time("deb_edge11", m0, (s0 + 1) % 60);
    end
    chk_time("deb_once", m0, (s0 + 1) % 60);
`else
    m0 = 0;
    chk("post_reset_state", int'(state), m0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
